// File: rtl/conv_ctrl_pkg.sv
// Shared state encoding and width helpers for the convolution BRAM/shift-register controller.
package conv_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Each bank stores ceil(IMG_H/FILTER_L) image rows back to back.
  function automatic int bank_addr_w(int img_w, int img_h, int filter_l);
    return $clog2(((img_h + filter_l - 1) / filter_l) * img_w);
  endfunction

  function automatic int result_addr_w(int img_w, int img_h, int filter_l);
    return $clog2((img_w - filter_l + 1) * (img_h - filter_l + 1));
  endfunction

  localparam int DEF_IMG_W                 = 16;
  localparam int DEF_IMG_H                 = 16;
  localparam int DEF_FILTER_L              = 3;
  localparam int DEF_RESULT_W              = DEF_IMG_W - DEF_FILTER_L + 1;
  localparam int DEF_RESULT_H              = DEF_IMG_H - DEF_FILTER_L + 1;
  localparam int DEF_BANK_ADDR_WIDTH       = bank_addr_w(DEF_IMG_W, DEF_IMG_H, DEF_FILTER_L);
  localparam int DEF_FILTER_L_ADDR_WIDTH   = $clog2(DEF_FILTER_L);
  localparam int DEF_RESULT_RAM_ADDR_WIDTH = result_addr_w(DEF_IMG_W, DEF_IMG_H, DEF_FILTER_L);

endpackage

// File: rtl/conv_ctrl_bank_addr_gen.sv
// Tracks the output row modulo FILTER_L and the row-block base, and derives
// each bank's read address for the current column without multiply/divide.
module conv_ctrl_bank_addr_gen
  import conv_ctrl_pkg::*;
#(
  parameter int IMG_W               = 16,
  parameter int FILTER_L            = 3,
  parameter int BANK_ADDR_WIDTH     = 6,
  parameter int FILTER_L_ADDR_WIDTH = 2,
  parameter int COL_W               = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                row_clr,
  input  logic                                row_inc,
  input  logic [COL_W-1:0]                    col,
  output logic [FILTER_L*BANK_ADDR_WIDTH-1:0] rdaddr,
  output logic [FILTER_L_ADDR_WIDTH-1:0]      rot
);

  localparam logic [FILTER_L_ADDR_WIDTH-1:0] ROT_LAST = FILTER_L_ADDR_WIDTH'(FILTER_L - 1);
  localparam logic [BANK_ADDR_WIDTH-1:0]     STRIDE   = BANK_ADDR_WIDTH'(IMG_W);

  logic [FILTER_L_ADDR_WIDTH-1:0] rmod_q, rmod_d;
  logic [BANK_ADDR_WIDTH-1:0]     blk_q, blk_d;

  always_comb begin
    rmod_d = rmod_q;
    blk_d  = blk_q;
    if (row_clr) begin
      rmod_d = '0;
      blk_d  = '0;
    end else if (row_inc) begin
      if (rmod_q == ROT_LAST) begin
        rmod_d = '0;
        blk_d  = blk_q + STRIDE;
      end else begin
        rmod_d = rmod_q + FILTER_L_ADDR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rmod_q <= '0;
      blk_q  <= '0;
    end else begin
      rmod_q <= rmod_d;
      blk_q  <= blk_d;
    end
  end

  assign rot = rmod_q;

  // Banks below the rotation point hold their window row in the next block.
  for (genvar b = 0; b < FILTER_L; b++) begin : g_bank
    localparam logic [FILTER_L_ADDR_WIDTH-1:0] B = FILTER_L_ADDR_WIDTH'(b);
    assign rdaddr[b*BANK_ADDR_WIDTH +: BANK_ADDR_WIDTH] =
      ((B < rmod_q) ? blk_q + STRIDE : blk_q) + BANK_ADDR_WIDTH'(col);
  end

endmodule

// File: rtl/conv_bram_sr_fast_ctrl.sv
// Pass controller: walks output rows x image columns, issues row-bank reads and
// hands a 1-cycle-delayed valid/rotation/result-address tag to the datapath.
module conv_bram_sr_fast_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter  int IMG_W                 = DEF_IMG_W,
  parameter  int IMG_H                 = DEF_IMG_H,
  parameter  int FILTER_L              = DEF_FILTER_L,
  localparam int RESULT_W              = IMG_W - FILTER_L + 1,
  localparam int RESULT_H              = IMG_H - FILTER_L + 1,
  localparam int BANK_ADDR_WIDTH       = bank_addr_w(IMG_W, IMG_H, FILTER_L),
  localparam int FILTER_L_ADDR_WIDTH   = $clog2(FILTER_L),
  localparam int RESULT_RAM_ADDR_WIDTH = $clog2(RESULT_W * RESULT_H)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  output logic                                busy,
  output logic                                done,
  output logic                                img_rden,
  output logic [FILTER_L*BANK_ADDR_WIDTH-1:0] img_rdaddr,
  output logic                                dpath_wren,
  output logic                                dpath_sum_en,
  output logic [FILTER_L_ADDR_WIDTH-1:0]      dpath_rotation_offset,
  output logic [RESULT_RAM_ADDR_WIDTH-1:0]    dpath_result_wraddr,
  input  logic                                last_val
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(RESULT_H + 1);
  localparam int RA = RESULT_RAM_ADDR_WIDTH;
  localparam logic [CW-1:0] C_LAST   = CW'(IMG_W - 1);
  localparam logic [CW-1:0] C_PRIME  = CW'(FILTER_L - 1);
  localparam logic [RW-1:0] R_LAST   = RW'(RESULT_H - 1);
  localparam logic [RA-1:0] R_STRIDE = RA'(RESULT_W);

  state_e                         state_q, state_d;
  logic [CW-1:0]                  c_q, c_d;
  logic [RW-1:0]                  r_q, r_d;
  logic [RA-1:0]                  rbase_q, rbase_d;
  logic                           row_clr, row_inc, rden;
  logic [FILTER_L_ADDR_WIDTH-1:0] rot;
  logic [RA-1:0]                  wraddr;
  logic                           wren_q;
  logic [FILTER_L_ADDR_WIDTH-1:0] rot_q;
  logic [RA-1:0]                  wraddr_q;

  conv_ctrl_bank_addr_gen #(
    .IMG_W              (IMG_W),
    .FILTER_L           (FILTER_L),
    .BANK_ADDR_WIDTH    (BANK_ADDR_WIDTH),
    .FILTER_L_ADDR_WIDTH(FILTER_L_ADDR_WIDTH),
    .COL_W              (CW)
  ) u_bank_addr (
    .clk    (clk),
    .reset  (reset),
    .row_clr(row_clr),
    .row_inc(row_inc),
    .col    (c_q),
    .rdaddr (img_rdaddr),
    .rot    (rot)
  );

  // Priming columns all land on the row's first result slot; column FILTER_L-1 rewrites it.
  assign wraddr = rbase_q + ((c_q >= C_PRIME) ? RA'(c_q - C_PRIME) : '0);

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    r_d     = r_q;
    rbase_d = rbase_q;
    row_clr = 1'b0;
    row_inc = 1'b0;
    rden    = 1'b0;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_ISSUE;
      S_ISSUE: begin
        rden = 1'b1;
        if (c_q == C_LAST) begin
          c_d = '0;
          if (r_q == R_LAST) begin
            r_d     = '0;
            rbase_d = '0;
            row_clr = 1'b1;
            state_d = S_DRAIN;
          end else begin
            r_d     = r_q + RW'(1);
            rbase_d = rbase_q + R_STRIDE;
            row_inc = 1'b1;
          end
        end else begin
          c_d = c_q + CW'(1);
        end
      end
      S_DRAIN: if (last_val) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      c_q      <= '0;
      r_q      <= '0;
      rbase_q  <= '0;
      wren_q   <= 1'b0;
      rot_q    <= '0;
      wraddr_q <= '0;
    end else begin
      state_q  <= state_d;
      c_q      <= c_d;
      r_q      <= r_d;
      rbase_q  <= rbase_d;
      wren_q   <= rden;
      rot_q    <= rot;
      wraddr_q <= wraddr;
    end
  end

  assign busy                  = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign done                  = (state_q == S_DONE);
  assign img_rden              = rden;
  assign dpath_wren            = wren_q;
  assign dpath_sum_en          = wren_q;
  assign dpath_rotation_offset = rot_q;
  assign dpath_result_wraddr   = wraddr_q;

endmodule

// File: tb/tb_conv_bram_sr_fast_ctrl.sv
// Scoreboard bench: expected read addresses and datapath tags are queued per pass
// from a row/column reference model; a negedge monitor pops and compares.
module tb_conv_bram_sr_fast_ctrl;

  localparam int W   = 5;
  localparam int H   = 5;
  localparam int L   = 3;
  localparam int RSW = W - L + 1;
  localparam int RSH = H - L + 1;
  localparam int BAW = 4;
  localparam int FAW = 2;
  localparam int RAW = 4;
  localparam int NPIX = RSH * W;

  logic                 clk = 1'b0;
  logic                 reset, start, last_val;
  logic                 busy, done, img_rden, dpath_wren, dpath_sum_en;
  logic [L*BAW-1:0]     img_rdaddr;
  logic [FAW-1:0]       dpath_rotation_offset;
  logic [RAW-1:0]       dpath_result_wraddr;

  always #5 clk = ~clk;

  conv_bram_sr_fast_ctrl #(.IMG_W(W), .IMG_H(H), .FILTER_L(L)) dut (
    .clk                  (clk),
    .reset                (reset),
    .start                (start),
    .busy                 (busy),
    .done                 (done),
    .img_rden             (img_rden),
    .img_rdaddr           (img_rdaddr),
    .dpath_wren           (dpath_wren),
    .dpath_sum_en         (dpath_sum_en),
    .dpath_rotation_offset(dpath_rotation_offset),
    .dpath_result_wraddr  (dpath_result_wraddr),
    .last_val             (last_val)
  );

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int exp_done = 0;

  logic [L*BAW-1:0]     rd_q[$];
  logic [FAW+RAW-1:0]   wr_q[$];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: for output row r the window spans image rows r..r+L-1; row h sits
  // in bank h%L at word (h/L)*W + column.
  task automatic push_pass();
    logic [L*BAW-1:0]   a;
    logic [FAW+RAW-1:0] t;
    for (int r = 0; r < RSH; r++) begin
      for (int c = 0; c < W; c++) begin
        a = '0;
        for (int h = r; h < r + L; h++)
          a[(h % L)*BAW +: BAW] = BAW'((h / L) * W + c);
        rd_q.push_back(a);
        t = {FAW'(r % L), RAW'(r * RSW + ((c >= L - 1) ? c - (L - 1) : 0))};
        wr_q.push_back(t);
      end
    end
  endtask

  // Monitor
  logic prev_rden = 1'b0;
  int   rd_run = 0;
  int   wr_run = 0;

  always @(negedge clk) begin
    logic [L*BAW-1:0]   ea;
    logic [FAW+RAW-1:0] et;
    if (reset) begin
      prev_rden = 1'b0;
      rd_run = 0;
      wr_run = 0;
    end else begin
      check("wren_is_rden_delayed", int'(dpath_wren), int'(prev_rden));
      check("sum_en_eq_wren", int'(dpath_sum_en), int'(dpath_wren));
      if (img_rden) begin
        rd_run++;
        if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
        else begin
          ea = rd_q.pop_front();
          for (int b = 0; b < L; b++)
            check($sformatf("rdaddr_b%0d", b), int'(img_rdaddr[b*BAW +: BAW]), int'(ea[b*BAW +: BAW]));
        end
      end else if (rd_run != 0) begin
        check("rden_run_len", rd_run, NPIX);
        rd_run = 0;
      end
      if (dpath_wren) begin
        wr_run++;
        if (wr_q.size() == 0) check("wr_unexpected", 1, 0);
        else begin
          et = wr_q.pop_front();
          check("rot_offset", int'(dpath_rotation_offset), int'(et[RAW +: FAW]));
          check("result_wraddr", int'(dpath_result_wraddr), int'(et[RAW-1:0]));
        end
      end else if (wr_run != 0) begin
        check("wren_run_len", wr_run, NPIX);
        wr_run = 0;
      end
      if (done) done_cnt++;
      prev_rden = img_rden;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (!(busy && !img_rden && !dpath_wren && rd_q.size() == 0 && wr_q.size() == 0) && n < 200) begin
      tick();
      n++;
    end
    check("reach_drain_in_time", int'(n < 200), 1);
  endtask

  task automatic run_pass(input int p, input int drain_dly);
    // last_val while idle must not produce done
    last_val = 1'b1;
    tick();
    last_val = 1'b0;
    check("idle_lastval_no_done", int'(done), 0);
    push_pass();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    repeat (2) tick();
    start = 1'b1;
    last_val = 1'(p % 2);
    tick();
    start = 1'b0;
    last_val = 1'b0;
    wait_drain();
    for (int i = 0; i < drain_dly; i++) begin
      start = (i == 0);
      check("drain_busy", int'(busy), 1);
      check("drain_no_done", int'(done), 0);
      tick();
    end
    start = 1'b0;
    last_val = 1'b1;
    tick();
    last_val = 1'b0;
    check("done_pulse", int'(done), 1);
    check("busy_low_at_done", int'(busy), 0);
    exp_done++;
    tick();
    check("done_one_cycle", int'(done), 0);
    check("done_count", done_cnt, exp_done);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    last_val = 1'b0;
    repeat (3) tick();
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_rden", int'(img_rden), 0);
    check("rst_wren", int'(dpath_wren), 0);
    check("rst_sum_en", int'(dpath_sum_en), 0);
    check("rst_rdaddr", int'(img_rdaddr), 0);
    check("rst_rot", int'(dpath_rotation_offset), 0);
    check("rst_wraddr", int'(dpath_result_wraddr), 0);
    reset = 1'b0;
    tick();
    check("idle_busy", int'(busy), 0);

    run_pass(0, 0);
    run_pass(1, 4);
    for (int p = 2; p < 6; p++) run_pass(p, $urandom_range(0, 6));

    // Abort mid-issue with reset
    push_pass();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    reset = 1'b1;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_rden", int'(img_rden), 0);
    check("abort_wren", int'(dpath_wren), 0);
    check("abort_sum_en", int'(dpath_sum_en), 0);
    check("abort_rdaddr", int'(img_rdaddr), 0);
    check("abort_rot", int'(dpath_rotation_offset), 0);
    check("abort_wraddr", int'(dpath_result_wraddr), 0);
    rd_q.delete();
    wr_q.delete();
    repeat (2) tick();
    reset = 1'b0;
    repeat (4) tick();
    check("abort_idle", int'(busy), 0);
    check("abort_no_done", done_cnt, exp_done);

    run_pass(7, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
